// File: rtl/camera_stream_pkg.sv
// Shared definitions for the camera stream: control-word encodings, parser
// states and error causes. Used by the parser and by the pattern generator.
package camera_stream_pkg;
   localparam logic [16:0] CW_FRAME_START = 17'h10000;
   localparam logic [16:0] CW_ROW_START   = 17'h10001;
   localparam logic [16:0] CW_FRAME_DONE  = 17'h1FFFF;

   typedef enum logic [1:0] {
      ST_WAIT_FRAME,
      ST_WAIT_ROW,
      ST_ROW,
      ST_WAIT_ROW_OR_DONE
   } parser_state_t;

   typedef enum logic [2:0] {
      ERR_NONE             = 3'd0,
      ERR_FRAME_RESTART    = 3'd1,
      ERR_ROW_SHORT        = 3'd2,
      ERR_PIXEL_UNEXPECTED = 3'd3,
      ERR_DONE_EARLY       = 3'd4,
      ERR_UNKNOWN_CTRL     = 3'd5,
      ERR_ROW_START_EXTRA  = 3'd6
   } err_code_t;
endpackage

// File: rtl/frame_stream_parser_if.sv
// Stream-side bundle of the parser: FIFO read port, pixel output handshake and
// status pulses. master = parser, slave = surrounding system.
interface frame_stream_parser_if;
   logic        queue_empty;
   logic [16:0] queue_data;
   logic        queue_rd_en;
   logic [15:0] pixel_data;
   logic [10:0] pixel_x;
   logic [10:0] pixel_y;
   logic        pixel_valid;
   logic        pixel_ready;
   logic        frame_start;
   logic        frame_done;
   logic        stream_error;
   logic [2:0]  error_code;

   modport master (
      input  queue_empty, queue_data, pixel_ready,
      output queue_rd_en, pixel_data, pixel_x, pixel_y, pixel_valid,
             frame_start, frame_done, stream_error, error_code
   );
   modport slave (
      output queue_empty, queue_data, pixel_ready,
      input  queue_rd_en, pixel_data, pixel_x, pixel_y, pixel_valid,
             frame_start, frame_done, stream_error, error_code
   );
endinterface

// File: rtl/queue_read_stage.sv
// Turns the 1-cycle-latency FIFO read port into a valid/ready stream using a
// single skid entry; FIFO data passes straight through when downstream is ready.
module queue_read_stage (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_queue_empty,
   input  logic [16:0] i_queue_data,
   output logic        o_queue_rd_en,
   output logic        o_valid,
   output logic [16:0] o_data,
   input  logic        i_ready
);
   logic        r_inflight;
   logic        r_skid_vld;
   logic [16:0] r_skid;

   // A word still in flight and not taken this cycle will occupy the skid
   // next cycle, so another read now would have nowhere to land.
   assign o_queue_rd_en = reset_n && !i_queue_empty && !r_skid_vld &&
                          !(r_inflight && !i_ready);

   assign o_valid = r_skid_vld | r_inflight;
   assign o_data  = r_skid_vld ? r_skid : i_queue_data;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_inflight <= 1'b0;
         r_skid_vld <= 1'b0;
         r_skid     <= '0;
      end else begin
         r_inflight <= o_queue_rd_en;
         if (r_skid_vld) begin
            if (i_ready) r_skid_vld <= 1'b0;
         end else if (r_inflight && !i_ready) begin
            r_skid_vld <= 1'b1;
            r_skid     <= i_queue_data;
         end
      end
   end
endmodule

// File: rtl/frame_stream_parser.sv
// Parses the 17-bit camera word stream into (x, y, RGB565) beats, framing
// pulses and error reports.
module frame_stream_parser
   import camera_stream_pkg::*;
#(
   parameter int FRAME_WIDTH  = 480,
   parameter int FRAME_HEIGHT = 272
) (
   input  logic                  clk,
   input  logic                  reset_n,
   frame_stream_parser_if.master bus
);
   localparam logic [10:0] LAST_COL = 11'(FRAME_WIDTH - 1);
   localparam logic [10:0] LAST_ROW = 11'(FRAME_HEIGHT - 1);

   logic          w_in_vld, w_in_rdy, w_take, w_is_pix;
   logic [16:0]   w_in_data;
   parser_state_t r_state, w_state_nx;
   logic [10:0]   r_row, r_col, w_row_nx, w_col_nx;
   logic          w_emit, w_fs, w_fd, w_err;
   err_code_t     w_code, r_err_code;
   logic          r_pix_vld, r_fs, r_fd, r_err;
   logic [15:0]   r_pix_data;
   logic [10:0]   r_pix_x, r_pix_y;

   queue_read_stage u_read (
      .clk           (clk),
      .reset_n       (reset_n),
      .i_queue_empty (bus.queue_empty),
      .i_queue_data  (bus.queue_data),
      .o_queue_rd_en (bus.queue_rd_en),
      .o_valid       (w_in_vld),
      .o_data        (w_in_data),
      .i_ready       (w_in_rdy)
   );

   // Only an in-row pixel needs the output register; everything else is
   // consumed immediately, even while a beat is stalled.
   assign w_is_pix = ~w_in_data[16];
   assign w_in_rdy = !(w_is_pix && r_state == ST_ROW) || !r_pix_vld || bus.pixel_ready;
   assign w_take   = w_in_vld && w_in_rdy;

   always_comb begin
      w_state_nx = r_state;
      w_row_nx   = r_row;
      w_col_nx   = r_col;
      w_emit     = 1'b0;
      w_fs       = 1'b0;
      w_fd       = 1'b0;
      w_err      = 1'b0;
      w_code     = ERR_NONE;
      if (w_take) begin
         if (w_in_data == CW_FRAME_START) begin
            w_err      = (r_state != ST_WAIT_FRAME);
            w_code     = ERR_FRAME_RESTART;
            w_fs       = 1'b1;
            w_row_nx   = '0;
            w_col_nx   = '0;
            w_state_nx = ST_WAIT_ROW;
         end else begin
            case (r_state)
               ST_WAIT_ROW: begin
                  if (w_in_data == CW_ROW_START) begin
                     w_col_nx   = '0;
                     w_state_nx = ST_ROW;
                  end else begin
                     w_err = 1'b1;
                     if (w_is_pix)                        w_code = ERR_PIXEL_UNEXPECTED;
                     else if (w_in_data == CW_FRAME_DONE) w_code = ERR_DONE_EARLY;
                     else                                 w_code = ERR_UNKNOWN_CTRL;
                  end
               end
               ST_ROW: begin
                  if (w_is_pix) begin
                     w_emit = 1'b1;
                     if (r_col == LAST_COL) begin
                        w_col_nx = '0;
                        if (r_row == LAST_ROW) begin
                           w_state_nx = ST_WAIT_ROW_OR_DONE;
                        end else begin
                           w_row_nx   = r_row + 11'd1;
                           w_state_nx = ST_WAIT_ROW;
                        end
                     end else begin
                        w_col_nx = r_col + 11'd1;
                     end
                  end else begin
                     w_err = 1'b1;
                     if (w_in_data == CW_ROW_START || w_in_data == CW_FRAME_DONE)
                        w_code = ERR_ROW_SHORT;
                     else
                        w_code = ERR_UNKNOWN_CTRL;
                  end
               end
               ST_WAIT_ROW_OR_DONE: begin
                  if (w_in_data == CW_FRAME_DONE) begin
                     w_fd       = 1'b1;
                     w_state_nx = ST_WAIT_FRAME;
                  end else begin
                     w_err = 1'b1;
                     if (w_is_pix)                       w_code = ERR_PIXEL_UNEXPECTED;
                     else if (w_in_data == CW_ROW_START) w_code = ERR_ROW_START_EXTRA;
                     else                                w_code = ERR_UNKNOWN_CTRL;
                  end
               end
               default: ;
            endcase
            if (w_err) w_state_nx = ST_WAIT_FRAME;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_WAIT_FRAME;
         r_row      <= '0;
         r_col      <= '0;
         r_pix_vld  <= 1'b0;
         r_pix_data <= '0;
         r_pix_x    <= '0;
         r_pix_y    <= '0;
         r_fs       <= 1'b0;
         r_fd       <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= ERR_NONE;
      end else begin
         r_state <= w_state_nx;
         r_row   <= w_row_nx;
         r_col   <= w_col_nx;
         r_fs    <= w_fs;
         r_fd    <= w_fd;
         r_err   <= w_err;
         if (w_err) r_err_code <= w_code;
         if (w_emit) begin
            r_pix_vld  <= 1'b1;
            r_pix_data <= w_in_data[15:0];
            r_pix_x    <= r_col;
            r_pix_y    <= r_row;
         end else if (bus.pixel_ready) begin
            r_pix_vld <= 1'b0;
         end
      end
   end

   assign bus.pixel_valid  = r_pix_vld;
   assign bus.pixel_data   = r_pix_data;
   assign bus.pixel_x      = r_pix_x;
   assign bus.pixel_y      = r_pix_y;
   assign bus.frame_start  = r_fs;
   assign bus.frame_done   = r_fd;
   assign bus.stream_error = r_err;
   assign bus.error_code   = r_err_code;
endmodule

// File: tb/tb_frame_stream_parser.sv
// Scoreboard bench: a word-level frame model predicts beats and pulses as words
// are queued; a monitor compares whatever the parser presents.
module tb_frame_stream_parser;
   import camera_stream_pkg::*;
   localparam int W = 4;
   localparam int H = 2;

   typedef struct {
      logic [15:0] d;
      logic [10:0] x;
      logic [10:0] y;
   } pix_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        q_empty = 1'b1;
   logic [16:0] q_data = '0;
   logic        rdy = 1'b1;

   frame_stream_parser_if bus();
   assign bus.queue_empty = q_empty;
   assign bus.queue_data  = q_data;
   assign bus.pixel_ready = rdy;

   frame_stream_parser #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   logic [16:0] fifo[$];
   pix_t        exp_pix[$];
   logic [5:0]  exp_evt[$];   // {frame_start, frame_done, stream_error, code}
   int          checks = 0;
   int          fails = 0;
   int          cyc = 0;
   int          rdy_mode = 0;
   bit          chk_en = 1'b1;
   bit          m_open = 1'b0;
   bit          m_row_open = 1'b0;
   int          m_k = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // FIFO with one-cycle read latency.
   initial forever begin
      @(posedge clk);
      cyc++;
      if (bus.queue_rd_en && fifo.size() > 0) q_data <= fifo.pop_front();
      q_empty <= (fifo.size() == 0);
   end

   initial begin
      int n;
      n = 0;
      forever begin
         @(posedge clk);
         #1;
         n++;
         case (rdy_mode)
            0:       rdy = 1'b1;
            1:       rdy = (n % 4 == 0) || (n % 4 == 3);
            2:       rdy = 1'($urandom_range(0, 1));
            default: rdy = 1'b0;
         endcase
      end
   end

   // Frame model: k counts pixels accepted in the open frame, so the pixel
   // position is simply (k mod W, k div W).
   task automatic model_word(input logic [16:0] w);
      logic [5:0] ev;
      pix_t       p;
      ev = '0;
      if (w == CW_FRAME_START) begin
         ev = m_open ? 6'b101_001 : 6'b100_000;
         m_open = 1'b1;
         m_row_open = 1'b0;
         m_k = 0;
      end else if (m_open) begin
         if (!w[16]) begin
            if (m_row_open) begin
               p.d = w[15:0];
               p.x = 11'(m_k % W);
               p.y = 11'(m_k / W);
               exp_pix.push_back(p);
               m_k++;
               if (m_k % W == 0) m_row_open = 1'b0;
            end else ev = {3'b001, 3'd3};
         end else if (w == CW_ROW_START) begin
            if (m_row_open)     ev = {3'b001, 3'd2};
            else if (m_k == W*H) ev = {3'b001, 3'd6};
            else                m_row_open = 1'b1;
         end else if (w == CW_FRAME_DONE) begin
            if (m_row_open) ev = {3'b001, 3'd2};
            else if (m_k == W*H) begin
               ev = 6'b010_000;
               m_open = 1'b0;
            end else ev = {3'b001, 3'd4};
         end else ev = {3'b001, 3'd5};
         if (ev[3]) begin
            m_open = 1'b0;
            m_row_open = 1'b0;
         end
      end
      if (ev != '0) exp_evt.push_back(ev);
      fifo.push_back(w);
   endtask

   function automatic logic [16:0] px(input int v);
      return {1'b0, 16'(v)};
   endfunction

   task automatic push_frame(input int base);
      model_word(CW_FRAME_START);
      for (int r = 0; r < H; r++) begin
         model_word(CW_ROW_START);
         for (int c = 0; c < W; c++) model_word(px(base + r*W + c));
      end
      model_word(CW_FRAME_DONE);
   endtask

   task automatic gen_frame(input int corrupt_pct);
      logic [16:0] w;
      for (int i = 0; i < 2 + H*(W+1); i++) begin
         if (i == 0)                      w = CW_FRAME_START;
         else if (i == 1 + H*(W+1))       w = CW_FRAME_DONE;
         else if ((i - 1) % (W + 1) == 0) w = CW_ROW_START;
         else                             w = px(int'($urandom));
         if ($urandom_range(0, 99) < corrupt_pct) begin
            case ($urandom_range(0, 4))
               0:       w = CW_FRAME_START;
               1:       w = CW_ROW_START;
               2:       w = CW_FRAME_DONE;
               3:       w = {1'b1, 16'($urandom)};
               default: w = px(int'($urandom));
            endcase
         end
         model_word(w);
      end
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      while ((fifo.size() != 0 || exp_pix.size() != 0 || exp_evt.size() != 0) && n < 4000) begin
         @(posedge clk);
         n++;
      end
      repeat (6) @(posedge clk);
      checks++;
      if (n >= 4000 || exp_pix.size() != 0 || exp_evt.size() != 0) begin
         fails++;
         $display("FAIL drain_%s: beats left %0d, events left %0d, cycles %0d",
                  nm, exp_pix.size(), exp_evt.size(), n);
      end
   endtask

   // Monitor: beats, pulses, output hold under stall, no bubbles inside a row.
   initial begin
      bit          prev_stall;
      pix_t        prev, e;
      logic [5:0]  ev;
      int          last_beat;
      prev_stall = 1'b0;
      last_beat = 0;
      forever begin
         @(negedge clk);
         if (!reset_n || !chk_en) prev_stall = 1'b0;
         else begin
            if (prev_stall) begin
               chk("hold_valid", 32'(bus.pixel_valid), 32'd1);
               chk("hold_beat", {bus.pixel_data, bus.pixel_x, bus.pixel_y}, {prev.d, prev.x, prev.y});
            end
            if (bus.pixel_valid) begin
               prev.d = bus.pixel_data;
               prev.x = bus.pixel_x;
               prev.y = bus.pixel_y;
               prev_stall = !bus.pixel_ready;
               if (bus.pixel_ready) begin
                  if (exp_pix.size() == 0) begin
                     checks++;
                     fails++;
                     $display("FAIL beat_unexpected: got x=%0d y=%0d data=%0h, none expected",
                              bus.pixel_x, bus.pixel_y, bus.pixel_data);
                  end else begin
                     e = exp_pix.pop_front();
                     chk("beat_data", 32'(bus.pixel_data), 32'(e.d));
                     chk("beat_x", 32'(bus.pixel_x), 32'(e.x));
                     chk("beat_y", 32'(bus.pixel_y), 32'(e.y));
                  end
                  if (rdy_mode == 0 && bus.pixel_x != 0) chk("row_no_bubble", 32'(cyc - last_beat), 32'd1);
                  last_beat = cyc;
               end
            end else prev_stall = 1'b0;
            ev = {bus.frame_start, bus.frame_done, bus.stream_error,
                  bus.stream_error ? bus.error_code : 3'd0};
            if (ev != '0) begin
               if (exp_evt.size() == 0) chk("event_unexpected", 32'(ev), 32'd0);
               else                     chk("event", 32'(ev), 32'(exp_evt.pop_front()));
            end
         end
      end
   end

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_rd_en", 32'(bus.queue_rd_en), 32'd0);
      chk("rst_valid", 32'(bus.pixel_valid), 32'd0);
      chk("rst_pulses", {bus.frame_start, bus.frame_done, bus.stream_error}, 32'd0);
      chk("rst_code", 32'(bus.error_code), 32'd0);
      reset_n = 1'b1;

      rdy_mode = 0;                         // nominal frame
      push_frame(16'h100);
      drain("nominal");

      rdy_mode = 1;                         // backpressure 1,0,0,1
      push_frame(16'h200);
      drain("backpressure");

      rdy_mode = 0;                         // short row, then ignored pixels
      model_word(CW_FRAME_START); model_word(CW_ROW_START);
      model_word(px(1)); model_word(px(2)); model_word(CW_ROW_START);
      model_word(px(3)); model_word(px(4)); model_word(CW_ROW_START);
      push_frame(16'h300);
      drain("short_row");

      model_word(CW_FRAME_START); model_word(CW_ROW_START); model_word(px(5));
      push_frame(16'h400);                  // restart mid-row
      drain("restart");

      model_word(CW_FRAME_START); model_word(CW_ROW_START); model_word(px(6));
      model_word(17'h1ABCD);                // unknown ctrl in ROW
      model_word(CW_FRAME_START); model_word(px(7));        // pixel in WAIT_ROW
      model_word(CW_FRAME_START); model_word(CW_ROW_START);
      for (int c = 0; c < W; c++) model_word(px(8 + c));
      model_word(CW_FRAME_DONE);            // done early
      model_word(17'h1ABCD);                // ignored while idle
      model_word(CW_FRAME_START);
      for (int r = 0; r < H; r++) begin
         model_word(CW_ROW_START);
         for (int c = 0; c < W; c++) model_word(px(r*W + c));
      end
      model_word(CW_ROW_START);             // extra row start
      drain("errors");

      rdy_mode = 2;
      for (int f = 0; f < 40; f++) gen_frame((f % 4 == 0) ? 0 : 8);
      drain("random");

      // Reset while row 1 is in progress and the FIFO still holds words.
      chk_en = 1'b0;
      rdy_mode = 0;
      fifo.push_back(CW_FRAME_START);
      for (int r = 0; r < H; r++) begin
         fifo.push_back(CW_ROW_START);
         for (int c = 0; c < W; c++) fifo.push_back(px(16'h500 + r*W + c));
      end
      fifo.push_back(CW_FRAME_DONE);
      for (int i = 0; i < 4; i++) fifo.push_back(px(16'h600 + i));
      n = 0;
      while (!(bus.pixel_valid && bus.pixel_y == 11'd1) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("reach_row1", 32'(n < 200), 32'd1);
      rdy_mode = 3;
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      chk("mid_rst_rd_en", 32'(bus.queue_rd_en), 32'd0);
      chk("mid_rst_valid", 32'(bus.pixel_valid), 32'd0);
      chk("mid_rst_beat", {bus.pixel_data, bus.pixel_x, bus.pixel_y}, 32'd0);
      chk("mid_rst_pulses", {bus.frame_start, bus.frame_done, bus.stream_error}, 32'd0);
      chk("mid_rst_code", 32'(bus.error_code), 32'd0);
      exp_pix.delete();
      exp_evt.delete();
      m_open = 1'b0;
      m_row_open = 1'b0;
      m_k = 0;
      repeat (3) @(posedge clk);
      #2 reset_n = 1'b1;
      chk_en = 1'b1;
      rdy_mode = 0;
      push_frame(16'h700);                  // leftovers ahead of it must be ignored
      drain("after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule

// File: doc/frame_stream_parser.md
FRAME_STREAM_PARSER -- requirements
Module: frame_stream_parser

Interface
REQ-001 Parameter FRAME_WIDTH, default 480, pixels per row.
REQ-002 Parameter FRAME_HEIGHT, default 272, rows per frame.
REQ-003 Ports, in order:
- clk  in  1  single clock.
- reset_n  in  1  reset, asynchronous, active-low.
- queue_empty  in  1  stream FIFO empty.
- queue_data  in  17  FIFO read data, valid the cycle after queue_rd_en.
- queue_rd_en  out  1  FIFO read strobe.
- pixel_data  out  16  RGB565.
- pixel_x  out  11  column of pixel_data.
- pixel_y  out  11  row of pixel_data.
- pixel_valid  out  1  output beat valid.
- pixel_ready  in  1  downstream accepts beat.
- frame_start  out  1  one-cycle pulse.
- frame_done  out  1  one-cycle pulse.
- stream_error  out  1  one-cycle pulse.
- error_code  out  3  cause; held until next error or reset.

Function
REQ-004 Word decoding:
- bit16=0: pixel, bits15:0 = RGB565.
- 17'h10000: FRAME_START.
- 17'h10001: ROW_START.
- 17'h1FFFF: FRAME_DONE.
- Any other bit16=1 word: unknown control.
REQ-005 States are WAIT_FRAME, WAIT_ROW, ROW, and WAIT_ROW_OR_DONE.
REQ-006 WAIT_FRAME:
- Discard everything except FRAME_START.
- On FRAME_START: row=0, col=0, pulse frame_start, go to WAIT_ROW.
REQ-007 WAIT_ROW: ROW_START sets col=0 and goes to ROW.
REQ-008 ROW pixel handling:
- Each pixel emits one beat with pixel_x=col, pixel_y=row, then col increments.
- After col reaches FRAME_WIDTH-1: if row==FRAME_HEIGHT-1, go to WAIT_ROW_OR_DONE with row unchanged; else increment row and go to WAIT_ROW.
REQ-009 WAIT_ROW_OR_DONE: FRAME_DONE pulses frame_done on acceptance of the word, then goes to WAIT_FRAME.
REQ-010 Any word not permitted by REQ-006..REQ-009 pulses stream_error, sets error_code, and goes to WAIT_FRAME, except FRAME_START (REQ-011).
REQ-011 FRAME_START outside WAIT_FRAME:
- Raise error 3'd1 (FRAME_RESTART).
- Then act as REQ-006, starting a new frame in the same cycle.
REQ-012 error_code values:
- 1 FRAME_RESTART.
- 2 ROW_SHORT: ROW_START or FRAME_DONE received in ROW.
- 3 PIXEL_UNEXPECTED: pixel outside ROW.
- 4 DONE_EARLY: FRAME_DONE in WAIT_ROW.
- 5 UNKNOWN_CTRL.
- 6 ROW_START_EXTRA: ROW_START in WAIT_ROW_OR_DONE.
REQ-013 FIFO read latency is 1 cycle; the parser keeps a one-entry skid register.
REQ-014 queue_rd_en SHALL be high only when: !queue_empty, the skid register is empty, and no in-flight read could overflow the storage.
REQ-015 Control words never produce pixel_valid; they are consumed in one cycle.
REQ-016 Pixel latency: queue_rd_en in cycle N gives pixel_valid no earlier than N+2.
REQ-017 Throughput: with queue_empty=0 and pixel_ready=1, one pixel per cycle is sustained, with no bubbles inside a row.
REQ-018 Output hold: while pixel_valid=1 and pixel_ready=0, pixel_data, pixel_x and pixel_y SHALL hold stable and no word is lost or duplicated.
REQ-019 col and row are 11 bits and never exceed FRAME_WIDTH-1 and FRAME_HEIGHT-1.
REQ-020 Pulses (frame_start, frame_done, stream_error) are single-cycle and independent of pixel_ready.

Reset
REQ-021 Asserting reset_n=0 asynchronously sets:
- state=WAIT_FRAME.
- queue_rd_en=0, pixel_valid=0, pixel_data=0, pixel_x=0, pixel_y=0.
- frame_start=0, frame_done=0, stream_error=0, error_code=0.
- skid register empty, row=0, col=0.
REQ-022 Reset mid-frame discards buffered words; after release, stream data is ignored until a FRAME_START.

Structure
REQ-023 Control-word constants, the error-code enum and the state enum SHALL live in shared package camera_stream_pkg, which the pattern generator also uses.
REQ-024 FIFO-latency handling and the skid register SHALL be in sub-module queue_read_stage (17-bit valid/ready output); the parser FSM sits downstream of it.

Verification (FRAME_WIDTH=4, FRAME_HEIGHT=2)
REQ-025 Nominal frame: stream 10000,10001,p0..p3,10001,p4..p7,1FFFF with pixel_ready=1 -> 8 beats, (x,y) from (0,0) to (3,1); one frame_start; one frame_done; no error.
REQ-026 Backpressure: same stream with pixel_ready toggling 1,0,0,1 -> identical beat sequence, outputs stable while stalled, queue_rd_en never overflows skid.
REQ-027 Short row: 10000,10001,p0,p1,10001 -> stream_error pulse, error_code=2, parser then ignores pixels until 10000.
REQ-028 Restart: 10000,10001,p0,10000,10001,p0..p3 -> error_code=1, second frame starts with beat at (0,0), frame_start pulses twice.
REQ-029 Unknown control 1ABCD in ROW -> error_code=5; also a pixel in WAIT_ROW -> error_code=3.
REQ-030 Reset pulse during row 1 with FIFO non-empty -> all outputs at reset values; the next 10000 frame parses cleanly.
